// File: rtl/pc_gen.sv
// Fetch-address generator: incrementing PC with valid/ready handshake, stall,
// prioritised trap/redirect and a direct-mapped BTB for next-PC prediction.
module pc_gen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned       INST_BYTES  = 4,
  parameter int unsigned       BTB_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              btb_upd_valid_i,
  input  logic [ADDR_W-1:0] btb_upd_pc_i,
  input  logic [ADDR_W-1:0] btb_upd_target_i,
  input  logic              btb_upd_taken_i
);

  localparam int unsigned       A          = $clog2(INST_BYTES);
  localparam int unsigned       I          = $clog2(BTB_ENTRIES);
  localparam int unsigned       TAG_W      = ADDR_W - A - I;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - {{(ADDR_W-1){1'b0}}, 1'b1});

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;

  logic [BTB_ENTRIES-1:0] btb_valid_r;
  logic [TAG_W-1:0]       btb_tag_r [BTB_ENTRIES];
  logic [ADDR_W-1:0]      btb_tgt_r [BTB_ENTRIES];

  logic              run_s, acc_s, hit_s, upd_match_s;
  logic [I-1:0]      look_idx_s, upd_idx_s;
  logic [TAG_W-1:0]  look_tag_s, upd_tag_s;
  logic [ADDR_W-1:0] upd_pc_s;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  assign run_s      = (state_r == RUN);
  assign pc_o       = pc_r;
  assign pc_valid_o = run_s & ~stall_i;
  assign acc_s      = pc_valid_o & fetch_ready_i;

  // Lookup reads the array as it stood before this edge's update (no bypass).
  assign look_idx_s    = pc_r[A+I-1:A];
  assign look_tag_s    = pc_r[ADDR_W-1:A+I];
  assign hit_s         = run_s & btb_valid_r[look_idx_s] & (btb_tag_r[look_idx_s] == look_tag_s);
  assign pred_taken_o  = hit_s;
  assign pred_target_o = hit_s ? btb_tgt_r[look_idx_s] : {ADDR_W{1'b0}};

  assign upd_pc_s    = align(btb_upd_pc_i);
  assign upd_idx_s   = upd_pc_s[A+I-1:A];
  assign upd_tag_s   = upd_pc_s[ADDR_W-1:A+I];
  assign upd_match_s = (btb_tag_r[upd_idx_s] == upd_tag_s);

  // FSM next-state: a single bubble cycle after reset, then run forever.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT:    state_nxt_s = RUN;
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = BOOT;
    endcase
  end

  // Next-PC selection in priority order.
  always_comb begin
    pc_nxt_s = pc_r;
    if (trap_valid_i) begin
      pc_nxt_s = align(trap_pc_i);
    end else if (redirect_valid_i) begin
      pc_nxt_s = align(redirect_pc_i);
    end else if (acc_s && hit_s) begin
      pc_nxt_s = pred_target_o;
    end else if (acc_s) begin
      pc_nxt_s = pc_r + STEP;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // BTB valid bits: install on taken, invalidate only on a tag match.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_r <= {BTB_ENTRIES{1'b0}};
    end else if (btb_upd_valid_i) begin
      if (btb_upd_taken_i) begin
        btb_valid_r[upd_idx_s] <= 1'b1;
      end else if (upd_match_s) begin
        btb_valid_r[upd_idx_s] <= 1'b0;
      end
    end
  end

  // BTB payload; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && btb_upd_valid_i && btb_upd_taken_i) begin
      btb_tag_r[upd_idx_s] <= upd_tag_s;
      btb_tgt_r[upd_idx_s] <= align(btb_upd_target_i);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen (RESET_PC = 'h100, 4-byte step, 8-entry BTB).
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_pc_i;
  logic        btb_upd_valid_i;
  logic [31:0] btb_upd_pc_i;
  logic [31:0] btb_upd_target_i;
  logic        btb_upd_taken_i;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .ADDR_W(32), .RESET_PC(32'h0000_0100), .INST_BYTES(4), .BTB_ENTRIES(8)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .btb_upd_valid_i(btb_upd_valid_i), .btb_upd_pc_i(btb_upd_pc_i),
    .btb_upd_target_i(btb_upd_target_i), .btb_upd_taken_i(btb_upd_taken_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, ready, rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        uv;
    logic [31:0] upc, utgt;
    logic        ut;
    logic        chk;
    logic [31:0] epc;
    logic        ev, ept;
    logic [31:0] etgt;
  } vec_t;

  function automatic vec_t mk(
    input logic rst_v, stall_v, ready_v, rv_v, input logic [31:0] rpc_v,
    input logic tv_v, input logic [31:0] tpc_v,
    input logic uv_v, input logic [31:0] upc_v, utgt_v, input logic ut_v,
    input logic chk_v, input logic [31:0] epc_v, input logic ev_v, ept_v,
    input logic [31:0] etgt_v);
    vec_t v;
    v.rst = rst_v; v.stall = stall_v; v.ready = ready_v; v.rv = rv_v; v.rpc = rpc_v;
    v.tv = tv_v; v.tpc = tpc_v; v.uv = uv_v; v.upc = upc_v; v.utgt = utgt_v; v.ut = ut_v;
    v.chk = chk_v; v.epc = epc_v; v.ev = ev_v; v.ept = ept_v; v.etgt = etgt_v;
    return v;
  endfunction

  task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare pre-edge outputs at negedge, then clock.
  task automatic run_vec(input vec_t v, input int n);
    rst = v.rst; stall_i = v.stall; fetch_ready_i = v.ready;
    redirect_valid_i = v.rv; redirect_pc_i = v.rpc;
    trap_valid_i = v.tv; trap_pc_i = v.tpc;
    btb_upd_valid_i = v.uv; btb_upd_pc_i = v.upc; btb_upd_target_i = v.utgt; btb_upd_taken_i = v.ut;
    @(negedge clk);
    if (v.chk) begin
      check("pc", n, pc_o, v.epc);
      check("valid", n, {31'd0, pc_valid_o}, {31'd0, v.ev});
      check("pred_taken", n, {31'd0, pred_taken_o}, {31'd0, v.ept});
      check("pred_target", n, pred_target_o, v.etgt);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    //          rst st rdy rv rpc           tv tpc   uv upc   utgt  ut chk epc           ev pt tgt
    tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h100,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h100,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h100,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h100,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h100,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h104,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h108,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h200,        0, 0,    0, 0,    0,    0, 1, 'h10C,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h200,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h204,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h400,        1, 'h80, 0, 0,    0,    0, 1, 'h208,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h403,        0, 0,    0, 0,    0,    0, 1, 'h80,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h400,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h10,         0, 0,    1, 'h10, 'h40, 1, 1, 'h400,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h10,         1, 1, 'h40));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h40,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h10,         0, 0,    1, 'h30, 'h0,  0, 1, 'h40,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h10,         1, 1, 'h40));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    1, 'h10, 'h0,  0, 1, 'h10,         1, 1, 'h40));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h10,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h14,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'hFFFF_FFFC,  0, 0,    0, 0,    0,    0, 1, 'h14,         1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'hFFFF_FFFC,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h0,          1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,            1, 'h83, 0, 0,    0,    0, 1, 'h0,          0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,            0, 0,    0, 0,    0,    0, 1, 'h80,         1, 0, 0));

    rst = 1'b1; stall_i = 1'b0; fetch_ready_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'd0; trap_valid_i = 1'b0; trap_pc_i = 32'd0;
    btb_upd_valid_i = 1'b0; btb_upd_pc_i = 32'd0; btb_upd_target_i = 32'd0; btb_upd_taken_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Same-cycle install is invisible to the lookup, then hits on the revisit.
    run_vec(mk(0, 0, 1, 0, 0,     0, 0, 1, 'h80,  'h120, 1, 1, 'h80,  1, 0, 0),     100);
    run_vec(mk(0, 0, 0, 1, 'h80,  0, 0, 0, 0,     0,     0, 1, 'h84,  1, 0, 0),     101);
    run_vec(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,     0, 1, 'h80,  1, 1, 'h120), 102);

    // Reset mid-request with a stalled fetch; BTB is cleared and updates in reset are dropped.
    run_vec(mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,     0, 0, 'h0,   0, 0, 0),     103);
    run_vec(mk(1, 0, 0, 0, 0,     0, 0, 1, 'h100, 'h200, 1, 1, 'h100, 0, 0, 0),     104);
    run_vec(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,     0, 1, 'h100, 0, 0, 0),     105);
    run_vec(mk(0, 0, 0, 1, 'h80,  0, 0, 0, 0,     0,     0, 1, 'h100, 1, 0, 0),     106);
    run_vec(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,     0, 1, 'h80,  1, 0, 0),     107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
